bcd_convert_arbiter: RTL and testbench

Shared, multi-cycle binary-to-BCD conversion engine with a round-robin front end. It accepts 8-bit unsigned values from up to NREQ requesters and serialises them through one iterative double-dabble datapath, one bit per clock. It returns a 3-digit packed BCD result tagged with the originating requester ID. It sits between the score/counter sources and the display driver, replacing one combinational converter per source.

---
 rtl/bcd_convert_arbiter_if.sv | 27 ++
 rtl/bcd_convert_arbiter.sv | 152 +++++++++++++++
 tb/tb_bcd_convert_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_arbiter_if.sv
// Request/response bundle for the shared binary-to-BCD engine.
// slave: the conversion engine; master: the requesters plus the result consumer.
`timescale 1ns/1ps
interface bcd_convert_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [11:0]       rsp_bcd;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_bin, rsp_ready,
    input  req_ready, rsp_valid, rsp_bcd, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_bin, rsp_ready,
    output req_ready, rsp_valid, rsp_bcd, rsp_id, busy
  );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Shared iterative (double-dabble) 8-bit binary to 3-digit BCD converter with
// a round-robin front end over NREQ requesters, one operand bit per clock.
// Optional build macro BCD_ARB_FIXED_PRIO_EN: lowest-index requester always
// wins and the round-robin pointer is removed; datapath and timing unchanged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; offers a one-hot grant to the winner
// SHIFT | one add-3/shift iteration per cycle, eight cycles total
// DONE  | result presented on rsp_*; held until rsp_ready
`timescale 1ns/1ps
module bcd_convert_arbiter #(
  parameter int NREQ = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_convert_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      bin_sr;
  logic [11:0]     acc_q;
  logic [11:0]     acc_adj;
  logic [2:0]      cnt_q;
  logic [IDW-1:0]  id_q;

  logic            any_req;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  cand;
  logic [7:0]      win_bin;
  logic [NREQ-1:0] ready_d;
  logic            xfer;

`ifndef BCD_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  last_grant;
`endif

  // Choose this cycle's winner among the valid requesters.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
`ifdef BCD_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the final assignment.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'(i);
      if (bus.req_valid[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
`else
    // Descending offset scan so the nearest requester after last_grant wins.
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (bus.req_valid[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
`endif
  end

  // Route the winning requester's operand to the shift register input.
  always_comb begin
    win_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_bin = bus.req_bin[8*i +: 8];
    end
  end

  // One-hot grant, offered only while idle and out of reset.
  always_comb begin
    ready_d = '0;
    if (rst_n && (state_q == IDLE) && any_req) ready_d[win_idx] = 1'b1;
  end

  assign xfer = (state_q == IDLE) && any_req;

  // Per-nibble add-3 correction on the pre-shift accumulator.
  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < 3; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Conversion datapath: load on grant, iterate in SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            bin_sr <= win_bin;
            acc_q  <= '0;
            cnt_q  <= '0;
            id_q   <= win_idx;
          end
        end
        SHIFT: begin
          {acc_q, bin_sr} <= {acc_adj, bin_sr} << 1;
          cnt_q           <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_ARB_FIXED_PRIO_EN
  // Round-robin pointer advances only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= IDW'(NREQ - 1);
    else if (xfer) last_grant <= win_idx;
  end
`endif

  assign bus.req_ready = ready_d;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_bcd   = acc_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter: directed scenarios plus a
// randomized traffic run checked against a transaction-level reference.
`timescale 1ns/1ps
module tb_bcd_convert_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   model_last;

  bcd_convert_arbiter_if #(.NREQ(NREQ)) bus ();

  bcd_convert_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Decimal digits of v, packed as {hundreds, tens, ones}.
  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Arbitration rule: who wins among valid requesters v given the previous grant.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef BCD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i + 0 * last;
`else
    for (int i = 1; i <= NREQ; i++) if (v[(last + i) % NREQ]) return (last + i) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] r;
    r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_bin   = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    @(negedge clk);
  endtask

  // Drives one request from requester k and collects the response (no checks).
  task automatic convert(input int k, input logic [7:0] v, output logic [11:0] bcd,
                         output int id, output int lat, output logic [NREQ-1:0] grant);
    int n;
    @(negedge clk);
    bus.req_bin[8*k +: 8] = v;
    bus.req_valid[k]      = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    grant = bus.req_ready;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[k] = 1'b0;
    #1;
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      @(negedge clk); #1; lat++;
    end
    bcd = bus.rsp_bcd;
    id  = int'(bus.rsp_id);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_bin   = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 12'h000) begin bad++; $display("FAIL reset_rsp_bcd: got %h want 000", bus.rsp_bcd); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    model_last = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [11:0] bcd;
    int id, lat;
    logic [NREQ-1:0] g;
    do_reset();
    convert(2, 8'd255, bcd, id, lat, g);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", g); end
    total++; if (lat != 8) begin bad++; $display("FAIL single_latency: got %0d want 8", lat); end
    total++; if (bcd !== 12'h255) begin bad++; $display("FAIL single_bcd: got %h want 255", bcd); end
    total++; if (id != 2) begin bad++; $display("FAIL single_id: got %0d want 2", id); end
  endtask

  task automatic test_values();
    int vals [7] = '{0, 9, 10, 99, 100, 128, 200};
    logic [11:0] bcd;
    logic [7:0] v;
    int id, lat, k;
    logic [NREQ-1:0] g;
    for (int i = 0; i < 19; i++) begin
      v = (i < 7) ? 8'(vals[i]) : 8'($urandom_range(0, 255));
      k = int'($urandom_range(0, NREQ - 1));
      convert(k, v, bcd, id, lat, g);
      total++; if (bcd !== to_bcd(int'(v))) begin bad++; $display("FAIL values_bcd: op %0d got %h want %h", v, bcd, to_bcd(int'(v))); end
      total++; if (id != k) begin bad++; $display("FAIL values_id: got %0d want %0d", id, k); end
      total++; if (lat != 8) begin bad++; $display("FAIL values_latency: got %0d want 8", lat); end
      total++; if (g !== onehot(k)) begin bad++; $display("FAIL values_grant: got %b want %b", g, onehot(k)); end
    end
  endtask

  task automatic test_contention();
    logic [7:0] opnd [NREQ];
    int gq [$];
    int exp_w, want, ngr, nrs, last_g, last_r;
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      opnd[k] = 8'($urandom_range(0, 255));
      bus.req_bin[8*k +: 8] = opnd[k];
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    ngr = 0; nrs = 0; last_g = -1; last_r = -1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.req_ready !== '0) begin
        exp_w = pick(bus.req_valid, model_last);
        total++; if (bus.req_ready !== onehot(exp_w)) begin bad++; $display("FAIL contention_grant: got %b want %b", bus.req_ready, onehot(exp_w)); end
        if (last_g >= 0) begin
          total++; if (c - last_g != 10) begin bad++; $display("FAIL contention_grant_gap: got %0d want 10", c - last_g); end
        end
        gq.push_back(exp_w);
        model_last = exp_w;
        last_g = c;
        ngr++;
      end
      if (bus.rsp_valid) begin
        want = (gq.size() > 0) ? gq.pop_front() : -1;
        total++; if (int'(bus.rsp_id) != want) begin bad++; $display("FAIL contention_rsp_id: got %0d want %0d", bus.rsp_id, want); end
        if (want >= 0) begin
          total++; if (bus.rsp_bcd !== to_bcd(int'(opnd[want]))) begin bad++; $display("FAIL contention_rsp_bcd: got %h want %h", bus.rsp_bcd, to_bcd(int'(opnd[want]))); end
        end
        if (last_r >= 0) begin
          total++; if (c - last_r != 10) begin bad++; $display("FAIL contention_rsp_gap: got %0d want 10", c - last_r); end
        end
        last_r = c;
        nrs++;
      end
      @(negedge clk);
    end
    total++; if (ngr != 6) begin bad++; $display("FAIL contention_grant_count: got %0d want 6", ngr); end
    total++; if (nrs != 6) begin bad++; $display("FAIL contention_rsp_count: got %0d want 6", nrs); end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    int n;
    do_reset();
    v = 8'($urandom_range(0, 255));
    bus.req_bin[15:8] = v;
    bus.req_valid[1]  = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.req_valid[1]   = 1'b0;
    bus.req_bin[31:24] = 8'd77;
    bus.req_valid[3]   = 1'b1;
    #1;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid: got %b want 1", bus.rsp_valid); end
      total++; if (bus.rsp_bcd !== to_bcd(int'(v))) begin bad++; $display("FAIL bp_rsp_bcd: got %h want %h", bus.rsp_bcd, to_bcd(int'(v))); end
      total++; if (bus.rsp_id !== 2'd1) begin bad++; $display("FAIL bp_rsp_id: got %0d want 1", bus.rsp_id); end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_req_ready: got %b want 0000", bus.req_ready); end
      @(negedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_accept_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant: got %b want 1000", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.req_bin[23:16] = 8'd255;
    bus.req_valid[2]   = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.req_valid      = 4'b1010;
    bus.req_bin[15:8]  = 8'd37;
    bus.req_bin[31:24] = 8'd201;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 12'h000) begin bad++; $display("FAIL rmid_rsp_bcd: got %h want 000", bus.rsp_bcd); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL rmid_rsp_id: got %0d want 0", bus.rsp_id); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_req_ready: got %b want 0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_first_grant: got %b want 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    total++; if (bus.rsp_id !== 2'd1) begin bad++; $display("FAIL rmid_rsp_id_after: got %0d want 1", bus.rsp_id); end
    total++; if (bus.rsp_bcd !== 12'h037) begin bad++; $display("FAIL rmid_rsp_bcd_after: got %h want 037", bus.rsp_bcd); end
    bus.req_valid = '0;
  endtask

  // Random requests and random backpressure against a transaction-level model:
  // the engine holds at most one job; its result appears 9 cycles after the grant
  // cycle and stays until accepted; grants are offered only while no job is held.
  task automatic test_random();
    logic [7:0] opnd [NREQ];
    logic [7:0] q_val;
    logic [NREQ-1:0] exp_rdy;
    int q_id, g_cyc, drop, w;
    bit acc_pend, exp_vld;
    do_reset();
    for (int k = 0; k < NREQ; k++) opnd[k] = '0;
    q_id = -1; g_cyc = 0; drop = -1; acc_pend = 1'b0; q_val = '0;
    for (int c = 0; c < 400; c++) begin
      if (drop >= 0) begin bus.req_valid[drop] = 1'b0; drop = -1; end
      if (acc_pend) begin q_id = -1; acc_pend = 1'b0; end
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req_valid[k] && $urandom_range(0, 3) == 0) begin
          opnd[k] = 8'($urandom_range(0, 255));
          bus.req_bin[8*k +: 8] = opnd[k];
          bus.req_valid[k] = 1'b1;
        end
      end
      #1;
      exp_rdy = '0;
      w = -1;
      if (q_id < 0 && bus.req_valid != '0) begin
        w = pick(bus.req_valid, model_last);
        exp_rdy = onehot(w);
      end
      exp_vld = (q_id >= 0) && (c - g_cyc >= 9);
      total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rand_req_ready: cyc %0d got %b want %b", c, bus.req_ready, exp_rdy); end
      total++; if (bus.rsp_valid !== exp_vld) begin bad++; $display("FAIL rand_rsp_valid: cyc %0d got %b want %b", c, bus.rsp_valid, exp_vld); end
      total++; if (bus.busy !== (q_id >= 0)) begin bad++; $display("FAIL rand_busy: cyc %0d got %b want %b", c, bus.busy, (q_id >= 0)); end
      if (exp_vld && bus.rsp_valid) begin
        total++; if (int'(bus.rsp_id) != q_id) begin bad++; $display("FAIL rand_rsp_id: cyc %0d got %0d want %0d", c, bus.rsp_id, q_id); end
        total++; if (bus.rsp_bcd !== to_bcd(int'(q_val))) begin bad++; $display("FAIL rand_rsp_bcd: cyc %0d got %h want %h", c, bus.rsp_bcd, to_bcd(int'(q_val))); end
      end
      if (w >= 0) begin
        q_id = w; q_val = opnd[w]; g_cyc = c; model_last = w; drop = w;
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      if (exp_vld && bus.rsp_ready) acc_pend = 1'b1;
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
  endtask

`ifdef BCD_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int ngr;
    do_reset();
    bus.req_bin[7:0]   = 8'd5;
    bus.req_bin[31:24] = 8'd6;
    bus.req_valid      = 4'b1001;
    bus.rsp_ready      = 1'b1;
    ngr = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (bus.req_ready !== '0) begin
        ngr++;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL fixed_grant: got %b want 0001", bus.req_ready); end
      end
      @(negedge clk);
    end
    total++; if (ngr != 5) begin bad++; $display("FAIL fixed_grant_count: got %0d want 5", ngr); end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_bin   = '0;
    bus.rsp_ready = 1'b0;
    model_last = NREQ - 1;
    test_reset();
    test_single();
    test_values();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef BCD_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
